// File: rtl/ctx_pkg.sv
// Shared definitions for the context save/restore sequencer: state encoding,
// register-index width and a state classification helper.
package ctx_pkg;

    localparam int CTX_REG_IDX_W = 3;
    // One extra bit so the index can also address the trailing checksum slot.
    localparam int CTX_CNT_W     = CTX_REG_IDX_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAVE,
        ST_RESTORE,
        ST_DRAIN,
        ST_DONE
    } ctx_state_t;

    function automatic logic ctx_is_active(input ctx_state_t s);
        return (s == ST_SAVE) || (s == ST_RESTORE) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/ctx_seq.sv
// Context sequencer: copies NUM_REGS CPU registers to a memory frame (save) or
// back (restore). Define CTX_SEQ_CHECKSUM_EN to append and verify an XOR byte.
module ctx_seq
    import ctx_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     save_req,
    input  logic                     restore_req,
    input  logic [ADDR_W-1:0]        base_addr,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [CTX_REG_IDX_W-1:0] rX_addr,
    input  logic [7:0]               rX,
    output logic                     rf_write_en,
    output logic [CTX_REG_IDX_W-1:0] rf_write_addr,
    output logic [7:0]               rf_in,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [7:0]               mem_wdata,
    output logic                     mem_write_en,
    output logic                     mem_read_en,
    input  logic [7:0]               mem_rdata
);

`ifdef CTX_SEQ_CHECKSUM_EN
    localparam int LAST_IDX = NUM_REGS;
`else
    localparam int LAST_IDX = NUM_REGS - 1;
`endif
    localparam logic [CTX_CNT_W-1:0] LAST_CNT = CTX_CNT_W'(LAST_IDX);

    ctx_state_t                 r_state;
    logic [CTX_CNT_W-1:0]       r_idx;
    logic [ADDR_W-1:0]          r_base;
    logic                       r_rd_valid;
    logic [CTX_REG_IDX_W-1:0]   r_rd_idx;

    logic                       w_run;
    logic                       w_accept;
    logic                       w_csum_slot;
    logic                       w_wr_en;
    logic                       w_rd_en;
    logic                       w_rf_we;
    logic [7:0]                 w_wdata;

    // Reset masks every output in the same cycle, before the state register
    // has had an edge to return to IDLE.
    assign w_run    = ~rst;
    assign w_accept = (r_state == ST_IDLE) && (save_req || restore_req);
    assign w_wr_en  = w_run && (r_state == ST_SAVE);
    assign w_rd_en  = w_run && (r_state == ST_RESTORE);
    assign w_rf_we  = w_run && r_rd_valid;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_base     <= '0;
            r_rd_valid <= 1'b0;
            r_rd_idx   <= '0;
        end else begin
            // Read data returns one cycle later; the checksum byte is never
            // forwarded to the register file.
            r_rd_valid <= (r_state == ST_RESTORE) && !w_csum_slot;
            r_rd_idx   <= r_idx[CTX_REG_IDX_W-1:0];
            case (r_state)
                ST_IDLE: begin
                    if (save_req) begin
                        r_state <= ST_SAVE;
                        r_base  <= base_addr;
                        r_idx   <= '0;
                    end else if (restore_req) begin
                        r_state <= ST_RESTORE;
                        r_base  <= base_addr;
                        r_idx   <= '0;
                    end
                end
                ST_SAVE: begin
                    if (r_idx == LAST_CNT) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + CTX_CNT_W'(1);
                    end
                end
                ST_RESTORE: begin
                    if (r_idx == LAST_CNT) begin
                        r_state <= ST_DRAIN;
                    end else begin
                        r_idx <= r_idx + CTX_CNT_W'(1);
                    end
                end
                ST_DRAIN: r_state <= ST_DONE;
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef CTX_SEQ_CHECKSUM_EN
    logic [7:0] r_csum;
    logic       r_err;
    logic       r_chk_valid;

    assign w_csum_slot = (r_idx == CTX_CNT_W'(NUM_REGS));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_csum      <= '0;
            r_err       <= 1'b0;
            r_chk_valid <= 1'b0;
        end else begin
            r_chk_valid <= (r_state == ST_RESTORE) && w_csum_slot;
            if (w_accept) begin
                r_csum <= '0;
                r_err  <= 1'b0;
            end else if (w_wr_en && !w_csum_slot) begin
                r_csum <= r_csum ^ rX;
            end else if (w_rf_we) begin
                r_csum <= r_csum ^ mem_rdata;
            end
            if (r_chk_valid && (mem_rdata != r_csum)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign w_wdata = w_csum_slot ? r_csum : rX;
    assign err     = w_run && r_err;
`else
    assign w_csum_slot = 1'b0;
    assign w_wdata     = rX;
    assign err         = 1'b0;
`endif

    assign busy          = w_run && ctx_is_active(r_state);
    assign done          = w_run && (r_state == ST_DONE);
    assign mem_write_en  = w_wr_en;
    assign mem_read_en   = w_rd_en;
    assign rf_write_en   = w_rf_we;
    assign rX_addr       = r_idx[CTX_REG_IDX_W-1:0];
    assign mem_addr      = r_base + ADDR_W'(r_idx);
    assign mem_wdata     = w_wdata;
    assign rf_write_addr = r_rd_idx;
    assign rf_in         = mem_rdata;

endmodule

// File: doc/ctx_seq.md
CTX_SEQ -- requirements
Module: ctx_seq

Interface
REQ-001 Parameter NUM_REGS, default 8, meaning number of CPU registers saved/restored, indices 0..NUM_REGS-1, range 1..8.
REQ-002 Parameter ADDR_W, default 16, meaning memory address width.
REQ-003 One clock; reset is synchronous and active-high; ports clk and rst.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 save_req  in  1  start save: registers -> memory.
REQ-007 restore_req  in  1  start restore: memory -> registers.
REQ-008 base_addr  in  ADDR_W  memory base of context frame, sampled at start.
REQ-009 busy  out  1  operation in progress.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 err  out  1  checksum mismatch flag, valid when done=1.
REQ-012 rX_addr  out  3  register-file read select.
REQ-013 rX  in  8  register-file read data, combinational from rX_addr.
REQ-014 rf_write_en, rf_write_addr, rf_in  out  1/3/8  register-file write port.
REQ-015 mem_addr  out  ADDR_W; mem_wdata  out  8; mem_write_en  out  1; mem_read_en  out  1; mem_rdata  in  8, valid exactly one cycle after mem_read_en.

Function
REQ-016 States: IDLE, SAVE, RESTORE, DRAIN, DONE.
REQ-017 IDLE: save_req=1 -> SAVE; else restore_req=1 -> RESTORE; save_req wins if both; base_addr latched and index cleared on the transition.
REQ-018 Requests in any state other than IDLE are ignored and not queued.
REQ-019 SAVE, index i: rX_addr=i, mem_addr=base+i, mem_wdata=rX, mem_write_en=1 in the same cycle; after i=NUM_REGS-1 -> DONE; save takes NUM_REGS cycles.
REQ-020 RESTORE, index i: mem_read_en=1, mem_addr=base+i; after i=NUM_REGS-1 -> DRAIN.
REQ-021 Data arrives one cycle after each read: rf_write_en=1, rf_write_addr=i, rf_in=mem_rdata; the last write occurs in DRAIN; DRAIN -> DONE.
REQ-022 DONE: done=1 for exactly one cycle, then IDLE; busy=1 in SAVE, RESTORE, and DRAIN only.
REQ-023 Address arithmetic is modulo 2^ADDR_W; base+i wraps silently.
REQ-024 Outside their active states, mem_write_en, mem_read_en, and rf_write_en are 0; address/data outputs are don't-care.
REQ-025 A request arriving in the DONE cycle is ignored; a request held high is accepted in the following IDLE cycle.

Reset
REQ-026 rst=1 forces IDLE and clears index, pipeline valid, and checksum accumulator.
REQ-027 While rst=1 and in the cycle after, busy=0, done=0, err=0, and all enables are 0.
REQ-028 Reset mid-operation aborts the operation: no further memory or register writes, and no done pulse.

Configuration
REQ-029 Macro CTX_SEQ_CHECKSUM_EN.
REQ-030 Defined: SAVE writes one extra byte, the XOR of all saved bytes, at base+NUM_REGS, so save takes NUM_REGS+1 cycles.
REQ-031 Defined: RESTORE reads NUM_REGS+1 bytes; the extra byte is compared with the XOR of the restored bytes and is not written to the register file.
REQ-032 Defined: err is registered, set on mismatch, held through the done cycle, and cleared at the next accepted request; registers are still written on mismatch.
REQ-033 Undefined: err is tied to 0, no extra memory access occurs, and timing is per REQ-019 to REQ-021.

Structure
REQ-034 Shared package ctx_pkg holds the state enum ctx_state_t and the constant CTX_REG_IDX_W=3.
REQ-035 No sub-module; index counter, read pipeline register, and XOR accumulator are inline.

Verification
REQ-036 Save: regs = 0x10..0x17, base=0x0100 -> writes 0x0100..0x0107 = 0x10..0x17 on consecutive cycles; done at cycle 9 after the request; busy high for 8 cycles.
REQ-037 Restore: mem 0x0200..0x0207 = 0xA0..0xA7 -> rf writes r0..r7 = 0xA0..0xA7, first write one cycle after the first read; done after DRAIN.
REQ-038 Wrap: save with base=0xFFFC -> writes at 0xFFFC..0xFFFF, then 0x0000..0x0003.
REQ-039 Contention: save_req and restore_req both high in IDLE -> save runs; restore_req pulsed during SAVE -> ignored, no read issued.
REQ-040 Reset: rst asserted at restore cycle 3 -> no rf_write_en after reset, no done, busy=0 next cycle.
REQ-041 With CTX_SEQ_CHECKSUM_EN: save regs all 0x01 -> byte at base+8 = 0x00; restore with base+8 corrupted to 0x55 -> err=1 with done, all 8 registers written.
